// File: rtl/hazard_scoreboard_if.sv
// Decode-stage handshake between the issue logic and the hazard scoreboard.
// The master drives the instruction/pipeline controls; the slave returns the stall decision.
interface hazard_scoreboard_if;
   logic        Issue_Valid;
   logic        Issue_Write;
   logic [2:0]  Issue_Dest;
   logic        Src1_Valid;
   logic [2:0]  Src1;
   logic        Src2_Valid;
   logic [2:0]  Src2;
   logic        Pipe_Hold;
   logic        Flush;
   logic        Stall;
   logic [7:0]  Pending;
   logic [15:0] Stall_Count;

   modport master (
      output Issue_Valid, Issue_Write, Issue_Dest,
      output Src1_Valid, Src1, Src2_Valid, Src2,
      output Pipe_Hold, Flush,
      input  Stall, Pending, Stall_Count
   );

   modport slave (
      input  Issue_Valid, Issue_Write, Issue_Dest,
      input  Src1_Valid, Src1, Src2_Valid, Src2,
      input  Pipe_Hold, Flush,
      output Stall, Pending, Stall_Count
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-stage stall controller. A shift register of {valid, dest} slots follows each
// issued instruction through EX/MEM/WB; Decode stalls while a source register it reads
// still has a write in flight. Branch flush squashes the youngest slots, and stall
// cycles are counted (saturating) for performance debug.
module hazard_scoreboard #(
   parameter int DEPTH      = 3,
   parameter int WB_BYPASS  = 1,
   parameter int KILL_DEPTH = 1
) (
   input logic                 clk,
   input logic                 rst,
   hazard_scoreboard_if.slave  bus
);

   // With write-before-read in the register file the oldest slot is already safe to read.
   localparam int NCHK = (WB_BYPASS != 0) ? DEPTH - 1 : DEPTH;

   logic [DEPTH-1:0] r_valid;
   logic [2:0]       r_dest [DEPTH];
   logic [15:0]      r_stall_count;

   logic [DEPTH-1:0] w_valid_next;
   logic [2:0]       w_dest_next [DEPTH];
   logic [DEPTH-1:0] w_hit1;
   logic [DEPTH-1:0] w_hit2;
   logic             w_hazard;
   logic             w_stall;
   logic             w_issue;
   logic [7:0]       w_pending;

   // Per-slot source match; slots beyond the checked window never cause a hazard.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_hit
         if (gi < NCHK) begin : g_chk
            assign w_hit1[gi] = r_valid[gi] && (r_dest[gi] == bus.Src1);
            assign w_hit2[gi] = r_valid[gi] && (r_dest[gi] == bus.Src2);
         end else begin : g_skip
            assign w_hit1[gi] = 1'b0;
            assign w_hit2[gi] = 1'b0;
         end
      end
   endgenerate

   assign w_hazard = (bus.Src1_Valid && (|w_hit1)) || (bus.Src2_Valid && (|w_hit2));
   // A flushed Decode instruction is being squashed anyway, so its hazard is irrelevant.
   assign w_stall  = bus.Pipe_Hold || (bus.Issue_Valid && w_hazard && !bus.Flush);
   assign w_issue  = bus.Issue_Valid && !w_stall && !bus.Flush;

   // Pending mask: one bit per register with any in-flight write.
   always_comb begin
      w_pending = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i]) begin
            w_pending[r_dest[i]] = 1'b1;
         end
      end
   end

   // Next slot contents: flush beats hold; otherwise advance one stage and insert issue or bubble.
   always_comb begin
      w_valid_next = r_valid;
      w_dest_next  = r_dest;
      if (bus.Flush) begin
         for (int i = 1; i < DEPTH; i++) begin
            w_valid_next[i] = r_valid[i-1];
            w_dest_next[i]  = r_dest[i-1];
         end
         w_valid_next[0] = 1'b0;
         w_dest_next[0]  = 3'd0;
         for (int i = 1; i < DEPTH; i++) begin
            if (i <= KILL_DEPTH) begin
               w_valid_next[i] = 1'b0;
               w_dest_next[i]  = 3'd0;
            end
         end
      end else if (!bus.Pipe_Hold) begin
         for (int i = 1; i < DEPTH; i++) begin
            w_valid_next[i] = r_valid[i-1];
            w_dest_next[i]  = r_dest[i-1];
         end
         w_valid_next[0] = w_issue && bus.Issue_Write;
         w_dest_next[0]  = (w_issue && bus.Issue_Write) ? bus.Issue_Dest : 3'd0;
      end
   end

   // Slot register; reset drops every pending write at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_dest[i] <= 3'd0;
         end
      end else begin
         r_valid <= w_valid_next;
         for (int i = 0; i < DEPTH; i++) begin
            r_dest[i] <= w_dest_next[i];
         end
      end
   end

   // Saturating count of real stall cycles (flush cycles excluded).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_count <= 16'h0000;
      end else if (w_stall && !bus.Flush && (r_stall_count != 16'hFFFF)) begin
         r_stall_count <= r_stall_count + 16'h0001;
      end
   end

   assign bus.Stall       = w_stall;
   assign bus.Pending     = w_pending;
   assign bus.Stall_Count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: dut_a uses write-before-read bypass,
// dut_b does not, so the oldest-slot boundary is exercised on both sides.
module tb_hazard_scoreboard;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   hazard_scoreboard_if bus_a ();
   hazard_scoreboard_if bus_b ();

   hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(1), .KILL_DEPTH(1)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(0), .KILL_DEPTH(1)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic iv, input logic iw, input logic [2:0] dst,
                          input logic s1v, input logic [2:0] s1,
                          input logic s2v, input logic [2:0] s2,
                          input logic hold, input logic fl);
      bus_a.Issue_Valid = iv;
      bus_a.Issue_Write = iw;
      bus_a.Issue_Dest  = dst;
      bus_a.Src1_Valid  = s1v;
      bus_a.Src1        = s1;
      bus_a.Src2_Valid  = s2v;
      bus_a.Src2        = s2;
      bus_a.Pipe_Hold   = hold;
      bus_a.Flush       = fl;
   endtask

   task automatic drive_b(input logic iv, input logic iw, input logic [2:0] dst,
                          input logic s1v, input logic [2:0] s1,
                          input logic s2v, input logic [2:0] s2,
                          input logic hold, input logic fl);
      bus_b.Issue_Valid = iv;
      bus_b.Issue_Write = iw;
      bus_b.Issue_Dest  = dst;
      bus_b.Src1_Valid  = s1v;
      bus_b.Src1        = s1;
      bus_b.Src2_Valid  = s2v;
      bus_b.Src2        = s2;
      bus_b.Pipe_Hold   = hold;
      bus_b.Flush       = fl;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();

      // Reset state: stall follows Pipe_Hold only
      check("rst_pending", 32'(bus_a.Pending), 32'h00);
      check("rst_count", 32'(bus_a.Stall_Count), 32'h0);
      check("rst_stall_nohold", 32'(bus_a.Stall), 32'h0);
      drive_a(0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      check("rst_stall_hold", 32'(bus_a.Stall), 32'h1);
      tick();
      drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      check("rst_count_after_hold", 32'(bus_a.Stall_Count), 32'h0);

      // RAW on R3: two stall cycles, issue on the third
      drive_a(1, 1, 3'd3, 0, 0, 0, 0, 0, 0);
      #1;
      check("t1_prod_stall", 32'(bus_a.Stall), 32'h0);
      tick();
      check("t1_pending", 32'(bus_a.Pending), 32'h08);
      drive_a(1, 0, 0, 1, 3'd3, 0, 0, 0, 0);
      #1;
      check("t1_stall_c1", 32'(bus_a.Stall), 32'h1);
      tick();
      check("t1_stall_c2", 32'(bus_a.Stall), 32'h1);
      tick();
      check("t1_stall_c3", 32'(bus_a.Stall), 32'h0);
      check("t1_count", 32'(bus_a.Stall_Count), 32'h2);
      tick();
      check("t1_drained", 32'(bus_a.Pending), 32'h00);

      // Independent back-to-back writes R1, R2
      drive_a(1, 1, 3'd1, 0, 0, 0, 0, 0, 0);
      #1;
      check("t2_stall_r1", 32'(bus_a.Stall), 32'h0);
      tick();
      drive_a(1, 1, 3'd2, 0, 0, 0, 0, 0, 0);
      #1;
      check("t2_stall_r2", 32'(bus_a.Stall), 32'h0);
      tick();
      check("t2_pending", 32'(bus_a.Pending), 32'h06);
      drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      tick();
      check("t2_drained", 32'(bus_a.Pending), 32'h00);

      // Flush kills producer R5 in slot 0
      drive_a(1, 1, 3'd5, 0, 0, 0, 0, 0, 0);
      tick();
      check("t3_pending_before", 32'(bus_a.Pending), 32'h20);
      drive_a(1, 0, 0, 1, 3'd5, 0, 0, 0, 1);
      #1;
      check("t3_flush_stall", 32'(bus_a.Stall), 32'h0);
      tick();
      check("t3_pending_after", 32'(bus_a.Pending), 32'h00);
      check("t3_count", 32'(bus_a.Stall_Count), 32'h2);
      drive_a(1, 0, 0, 1, 3'd5, 0, 0, 0, 0);
      #1;
      check("t3_consumer_stall", 32'(bus_a.Stall), 32'h0);
      tick();

      // Pipe_Hold freezes R4 in slot 0 for three cycles, then normal drain
      drive_a(1, 1, 3'd4, 0, 0, 0, 0, 0, 0);
      tick();
      drive_a(0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("t4_hold_stall%0d", i), 32'(bus_a.Stall), 32'h1);
         check($sformatf("t4_hold_pending%0d", i), 32'(bus_a.Pending), 32'h10);
         tick();
      end
      drive_a(1, 0, 0, 1, 3'd4, 0, 0, 0, 0);
      #1;
      check("t4_drain_c1", 32'(bus_a.Stall), 32'h1);
      tick();
      check("t4_drain_c2", 32'(bus_a.Stall), 32'h1);
      tick();
      check("t4_drain_c3", 32'(bus_a.Stall), 32'h0);
      check("t4_count", 32'(bus_a.Stall_Count), 32'h7);
      tick();
      drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      tick();

      // R7 in slot 1 and slot 2, both sources read R7
      drive_a(1, 1, 3'd7, 0, 0, 0, 0, 0, 0);
      drive_b(1, 1, 3'd7, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      check("t5_b_pending", 32'(bus_b.Pending), 32'h80);
      drive_a(1, 0, 0, 1, 3'd7, 1, 3'd7, 0, 0);
      drive_b(1, 0, 0, 1, 3'd7, 1, 3'd7, 0, 0);
      #1;
      check("t5_b_stall_c1", 32'(bus_b.Stall), 32'h1);
      check("t5_a_stall_c1", 32'(bus_a.Stall), 32'h1);
      tick();
      check("t5_b_stall_c2", 32'(bus_b.Stall), 32'h1);
      check("t5_a_stall_c2", 32'(bus_a.Stall), 32'h0);
      tick();
      check("t5_b_stall_c3", 32'(bus_b.Stall), 32'h0);
      check("t5_b_count", 32'(bus_b.Stall_Count), 32'h2);
      tick();

      // Saturation: R6 in flight, long hold, then reset clears everything
      drive_a(1, 1, 3'd6, 0, 0, 0, 0, 0, 0);
      tick();
      drive_a(0, 0, 0, 0, 0, 0, 0, 1, 0);
      repeat (65537) tick();
      check("t6_count_sat", 32'(bus_a.Stall_Count), 32'hFFFF);
      check("t6_pending_held", 32'(bus_a.Pending), 32'h40);
      tick();
      check("t6_count_hold", 32'(bus_a.Stall_Count), 32'hFFFF);
      drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      check("t6_rst_count", 32'(bus_a.Stall_Count), 32'h0);
      check("t6_rst_pending", 32'(bus_a.Pending), 32'h00);
      check("t6_rst_stall", 32'(bus_a.Stall), 32'h0);
      rst = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
